// File: rtl/stopwatch_defs.sv
// Shared definitions for the stopwatch core and its command front-end:
// core status encodings, command codes, controller states and lap width.
package stopwatch_defs;

    localparam int LAP_W = 14;  // {minutes[7:0], seconds[5:0]}

    typedef enum logic [1:0] {
        STATUS_IDLE    = 2'b00,
        STATUS_RUNNING = 2'b01,
        STATUS_PAUSED  = 2'b10,
        STATUS_INVALID = 2'b11
    } status_e;

    typedef enum logic [1:0] {
        CMD_NONE,
        CMD_START,
        CMD_STOP,
        CMD_RESET
    } cmd_e;

    typedef enum logic [1:0] {
        ST_READY,
        ST_ISSUE,
        ST_WAIT_ACK
    } state_e;

endpackage

// File: rtl/lap_fifo.sv
// Small synchronous FIFO holding lap times. Push while full is ignored
// (the caller flags the overflow); flush empties it and wins over push/pop.
module lap_fifo
    import stopwatch_defs::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = LAP_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign count_o = count_q;
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // Next pointer/count values; flush overrides any same-cycle push or pop.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Lap storage array.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; data_o is masked to zero while empty, so stale entries never leak out.
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/stopwatch_cmd_ctrl.sv
// Button front-end for the stopwatch core: synchronizes two buttons,
// turns rising edges into start/stop/reset pulses checked against the
// core status, and buffers lap times for a valid/ready consumer.
module stopwatch_cmd_ctrl
    import stopwatch_defs::*;
#(
    parameter int DEPTH       = 4,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     btn_ss,
    input  logic                     btn_lr,
    input  logic [7:0]               minutes,
    input  logic [5:0]               seconds,
    input  logic [1:0]               status,
    output logic                     start,
    output logic                     stop,
    output logic                     reset,
    output logic                     lap_valid,
    output logic [LAP_W-1:0]         lap_data,
    input  logic                     lap_ready,
    output logic [$clog2(DEPTH):0]   lap_count,
    output logic                     lap_ovf,
    output logic                     cmd_err
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    logic [1:0]    ss_sync_q, lr_sync_q;
    logic          ss_prev_q, lr_prev_q;
    logic          ss_edge_q, lr_edge_q;
    state_e        state_q, state_d;
    cmd_e          cmd_q, cmd_d;
    status_e       exp_q, exp_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          err_q, err_d;
    logic          ovf_q, ovf_d;
    logic          lap_push, lap_flush;
    logic          fifo_full, fifo_empty;
    status_e       status_s;

    assign status_s = status_e'(status);

    // Two-flop synchronizers followed by registered rising-edge detectors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_sync_q <= '0;
            lr_sync_q <= '0;
            ss_prev_q <= 1'b0;
            lr_prev_q <= 1'b0;
            ss_edge_q <= 1'b0;
            lr_edge_q <= 1'b0;
        end else begin
            ss_sync_q <= {ss_sync_q[0], btn_ss};
            lr_sync_q <= {lr_sync_q[0], btn_lr};
            ss_prev_q <= ss_sync_q[1];
            lr_prev_q <= lr_sync_q[1];
            ss_edge_q <= ss_sync_q[1] && !ss_prev_q;
            lr_edge_q <= lr_sync_q[1] && !lr_prev_q;
        end
    end

    // Command FSM: decode edges in READY, pulse in ISSUE, await status in WAIT_ACK.
    always_comb begin
        state_d   = state_q;
        cmd_d     = CMD_NONE;
        exp_d     = exp_q;
        timer_d   = timer_q;
        err_d     = err_q;
        lap_push  = 1'b0;
        lap_flush = 1'b0;
        case (state_q)
            ST_READY: begin
                timer_d = '0;
                // start/stop edge has priority; a simultaneous lap/reset edge is dropped
                if (ss_edge_q) begin
                    case (status_s)
                        STATUS_RUNNING: begin
                            cmd_d   = CMD_STOP;
                            exp_d   = STATUS_PAUSED;
                            state_d = ST_ISSUE;
                        end
                        STATUS_IDLE, STATUS_PAUSED: begin
                            cmd_d   = CMD_START;
                            exp_d   = STATUS_RUNNING;
                            state_d = ST_ISSUE;
                        end
                        default: err_d = 1'b1;
                    endcase
                end else if (lr_edge_q) begin
                    case (status_s)
                        STATUS_RUNNING: lap_push = 1'b1;
                        STATUS_PAUSED: begin
                            cmd_d     = CMD_RESET;
                            exp_d     = STATUS_IDLE;
                            state_d   = ST_ISSUE;
                            lap_flush = 1'b1;
                        end
                        STATUS_IDLE: lap_flush = 1'b1;
                        default:     err_d = 1'b1;
                    endcase
                end
            end
            ST_ISSUE: begin
                // the pulse register is high during this state; clearing it ends the pulse
                timer_d = '0;
                state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (status_s == exp_q) begin
                    state_d = ST_READY;
                end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_READY;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = ST_READY;
        endcase
    end

    // Sticky overflow: set by a capture into a full buffer, cleared by flush.
    always_comb begin
        ovf_d = ovf_q;
        if (lap_flush) begin
            ovf_d = 1'b0;
        end else if (lap_push && fifo_full) begin
            ovf_d = 1'b1;
        end
    end

    // FSM, pulse, timeout and sticky-flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_READY;
            cmd_q   <= CMD_NONE;
            exp_q   <= STATUS_IDLE;
            timer_q <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            exp_q   <= exp_d;
            timer_q <= timer_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
        end
    end

    // A single encoded command register keeps the three pulses mutually exclusive.
    assign start   = (cmd_q == CMD_START);
    assign stop    = (cmd_q == CMD_STOP);
    assign reset   = (cmd_q == CMD_RESET);
    assign lap_ovf = ovf_q;
    assign cmd_err = err_q;

    lap_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (LAP_W)
    ) u_lap_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (lap_push),
        .pop_i   (lap_ready),
        .flush_i (lap_flush),
        .data_i  ({minutes, seconds}),
        .data_o  (lap_data),
        .count_o (lap_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign lap_valid = !fifo_empty;

endmodule

// File: tb/tb_stopwatch_cmd_ctrl.sv
// Directed bench for stopwatch_cmd_ctrl with a minimal stopwatch-core model
// that follows start/stop/reset pulses when enabled.
module tb_stopwatch_cmd_ctrl;

    logic        clk;
    logic        rst_n;
    logic        btn_ss;
    logic        btn_lr;
    logic [7:0]  minutes;
    logic [5:0]  seconds;
    logic [1:0]  status;
    logic        start;
    logic        stop;
    logic        reset;
    logic        lap_valid;
    logic [13:0] lap_data;
    logic        lap_ready;
    logic [2:0]  lap_count;
    logic        lap_ovf;
    logic        cmd_err;

    int n_pass  = 0;
    int n_total = 0;
    int n_start = 0;
    int n_stop  = 0;
    int n_rst   = 0;
    bit core_auto = 1'b0;

    stopwatch_cmd_ctrl #(
        .DEPTH       (4),
        .ACK_TIMEOUT (15)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_ss    (btn_ss),
        .btn_lr    (btn_lr),
        .minutes   (minutes),
        .seconds   (seconds),
        .status    (status),
        .start     (start),
        .stop      (stop),
        .reset     (reset),
        .lap_valid (lap_valid),
        .lap_data  (lap_data),
        .lap_ready (lap_ready),
        .lap_count (lap_count),
        .lap_ovf   (lap_ovf),
        .cmd_err   (cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock, sample 1ns after the edge, count pulses, run core model.
    task automatic tick();
        @(posedge clk);
        #1;
        if (start) n_start++;
        if (stop)  n_stop++;
        if (reset) n_rst++;
        if (core_auto) begin
            if (start)      status = 2'b01;
            else if (stop)  status = 2'b10;
            else if (reset) status = 2'b00;
        end
    endtask

    // Raise the given buttons for 4 cycles (action lands on the 4th), then release and settle.
    task automatic press(input logic ss, input logic lr);
        btn_ss = ss;
        btn_lr = lr;
        repeat (4) tick();
        btn_ss = 1'b0;
        btn_lr = 1'b0;
        repeat (3) tick();
    endtask

    task automatic clear_counts();
        n_start = 0;
        n_stop  = 0;
        n_rst   = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; btn_ss = 1'b0; btn_lr = 1'b0; lap_ready = 1'b0;
        minutes = 8'd0; seconds = 6'd0; status = 2'b00;
        #3;
        n_total++;
        if ({start, stop, reset, lap_valid, lap_ovf, cmd_err} !== 6'b0)
            $display("FAIL reset_flags: got %b expected 000000", {start, stop, reset, lap_valid, lap_ovf, cmd_err});
        else n_pass++;
        n_total++;
        if (lap_data !== 14'd0) $display("FAIL reset_lap_data: got %0h expected 0", lap_data);
        else n_pass++;
        n_total++;
        if (lap_count !== 3'd0) $display("FAIL reset_lap_count: got %0d expected 0", lap_count);
        else n_pass++;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_start();
        core_auto = 1'b1;
        status = 2'b00;
        clear_counts();
        btn_ss = 1'b1;              // first sampled at next edge N
        repeat (3) tick();          // after N+2
        n_total++;
        if (start !== 1'b0) $display("FAIL start_early: got %b expected 0", start);
        else n_pass++;
        tick();                     // after N+3
        n_total++;
        if ({start, stop, reset} !== 3'b100) $display("FAIL start_pulse: got %b expected 100", {start, stop, reset});
        else n_pass++;
        tick();                     // after N+4
        n_total++;
        if (start !== 1'b0) $display("FAIL start_width: got %b expected 0", start);
        else n_pass++;
        repeat (5) tick();          // button held 10 cycles total
        btn_ss = 1'b0;
        repeat (4) tick();
        n_total++;
        if (n_start !== 1) $display("FAIL start_count: got %0d expected 1", n_start);
        else n_pass++;
        n_total++;
        if (cmd_err !== 1'b0) $display("FAIL start_err: got %b expected 0", cmd_err);
        else n_pass++;
    endtask

    task automatic test_lap();
        minutes = 8'd2;
        seconds = 6'd15;
        btn_lr = 1'b1;
        repeat (3) tick();          // after N+2
        n_total++;
        if (lap_valid !== 1'b0) $display("FAIL lap_early: got %b expected 0", lap_valid);
        else n_pass++;
        tick();                     // after N+3
        btn_lr = 1'b0;
        n_total++;
        if (lap_valid !== 1'b1) $display("FAIL lap_valid: got %b expected 1", lap_valid);
        else n_pass++;
        n_total++;
        if (lap_data !== {8'd2, 6'd15}) $display("FAIL lap_data: got %0h expected %0h", lap_data, {8'd2, 6'd15});
        else n_pass++;
        n_total++;
        if (lap_count !== 3'd1) $display("FAIL lap_count1: got %0d expected 1", lap_count);
        else n_pass++;
        repeat (3) tick();
        lap_ready = 1'b1;
        tick();
        lap_ready = 1'b0;
        n_total++;
        if ({lap_valid, lap_count} !== 4'b0_000) $display("FAIL lap_pop: got %b expected 0000", {lap_valid, lap_count});
        else n_pass++;
    endtask

    task automatic test_overflow();
        logic [13:0] exp_lap;
        for (int i = 0; i < 5; i++) begin
            minutes = 8'(10 + i);
            seconds = 6'(i);
            press(1'b0, 1'b1);
        end
        n_total++;
        if (lap_count !== 3'd4) $display("FAIL ovf_count: got %0d expected 4", lap_count);
        else n_pass++;
        n_total++;
        if (lap_ovf !== 1'b1) $display("FAIL ovf_flag: got %b expected 1", lap_ovf);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            exp_lap = {8'(10 + i), 6'(i)};
            n_total++;
            if (lap_data !== exp_lap) $display("FAIL ovf_read%0d: got %0h expected %0h", i, lap_data, exp_lap);
            else n_pass++;
            lap_ready = 1'b1;
            tick();
            lap_ready = 1'b0;
        end
        n_total++;
        if ({lap_valid, lap_count, lap_ovf} !== 5'b0_000_1)
            $display("FAIL ovf_drained: got %b expected 00001", {lap_valid, lap_count, lap_ovf});
        else n_pass++;
    endtask

    task automatic test_pause_reset();
        minutes = 8'd1;
        for (int i = 0; i < 3; i++) begin
            seconds = 6'(20 + i);
            press(1'b0, 1'b1);
        end
        n_total++;
        if (lap_count !== 3'd3) $display("FAIL pr_count3: got %0d expected 3", lap_count);
        else n_pass++;
        clear_counts();
        press(1'b1, 1'b0);          // RUNNING -> stop, model goes PAUSED
        n_total++;
        if (n_stop !== 1) $display("FAIL pr_stop: got %0d expected 1", n_stop);
        else n_pass++;
        btn_lr = 1'b1;
        repeat (4) tick();          // after N+3
        btn_lr = 1'b0;
        n_total++;
        if ({start, stop, reset} !== 3'b001) $display("FAIL pr_reset_pulse: got %b expected 001", {start, stop, reset});
        else n_pass++;
        n_total++;
        if ({lap_valid, lap_count, lap_ovf} !== 5'b0_000_0)
            $display("FAIL pr_flush: got %b expected 00000", {lap_valid, lap_count, lap_ovf});
        else n_pass++;
        repeat (4) tick();
        n_total++;
        if (n_rst !== 1) $display("FAIL pr_reset_count: got %0d expected 1", n_rst);
        else n_pass++;
    endtask

    task automatic test_timeout();
        core_auto = 1'b0;
        status = 2'b00;
        clear_counts();
        press(1'b1, 1'b0);          // start pulse after N+3; now after N+6
        press(1'b1, 1'b0);          // edge lands in WAIT_ACK; now after N+13
        n_total++;
        if (cmd_err !== 1'b0) $display("FAIL to_err_mid: got %b expected 0", cmd_err);
        else n_pass++;
        repeat (5) tick();          // after N+18: 14 wait cycles done
        n_total++;
        if (cmd_err !== 1'b0) $display("FAIL to_err_early: got %b expected 0", cmd_err);
        else n_pass++;
        tick();                     // after N+19: 15th wait cycle
        n_total++;
        if (cmd_err !== 1'b1) $display("FAIL to_err_set: got %b expected 1", cmd_err);
        else n_pass++;
        n_total++;
        if (n_start !== 1) $display("FAIL to_single_pulse: got %0d expected 1", n_start);
        else n_pass++;
    endtask

    task automatic test_both_and_rst();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        core_auto = 1'b1;
        status = 2'b01;
        minutes = 8'd5;
        seconds = 6'd30;
        press(1'b0, 1'b1);
        clear_counts();
        press(1'b1, 1'b1);
        n_total++;
        if ({n_start, n_stop, n_rst} !== {32'd0, 32'd1, 32'd0})
            $display("FAIL both_pulses: got start=%0d stop=%0d reset=%0d expected 0/1/0", n_start, n_stop, n_rst);
        else n_pass++;
        n_total++;
        if (lap_count !== 3'd1) $display("FAIL both_no_lap: got %0d expected 1", lap_count);
        else n_pass++;
        n_total++;
        if (cmd_err !== 1'b0) $display("FAIL both_err: got %b expected 0", cmd_err);
        else n_pass++;
        core_auto = 1'b0;           // status stays PAUSED: command never acknowledged
        btn_ss = 1'b1;
        repeat (4) tick();
        n_total++;
        if (start !== 1'b1) $display("FAIL rst_pre_pulse: got %b expected 1", start);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({start, stop, reset, lap_valid, lap_ovf, cmd_err} !== 6'b0)
            $display("FAIL rst_mid_flags: got %b expected 000000", {start, stop, reset, lap_valid, lap_ovf, cmd_err});
        else n_pass++;
        n_total++;
        if ({lap_count, lap_data} !== 17'd0) $display("FAIL rst_mid_fifo: got %0h expected 0", {lap_count, lap_data});
        else n_pass++;
        btn_ss = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_invalid_status();
        status = 2'b11;
        clear_counts();
        press(1'b0, 1'b1);
        n_total++;
        if (cmd_err !== 1'b1) $display("FAIL inv_err: got %b expected 1", cmd_err);
        else n_pass++;
        n_total++;
        if ({n_start, n_stop, n_rst} !== {32'd0, 32'd0, 32'd0} || lap_count !== 3'd0)
            $display("FAIL inv_no_action: got pulses=%0d count=%0d expected 0/0", n_start + n_stop + n_rst, lap_count);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_start();
        test_lap();
        test_overflow();
        test_pause_reset();
        test_timeout();
        test_both_and_rst();
        test_invalid_status();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
